// File: rtl/i2s_adc_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_adc_receiver
//  Description : I2S ADC deserializer; captures one channel's word into CLK.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_adc_receiver #(
    parameter int CHANNEL = 0,
    parameter int WIDTH   = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             AUD_BCLK,
    input  logic             AUD_ADCLRCK,
    input  logic             AUD_ADCDAT,
    output logic [WIDTH-1:0] adc_frame,
    output logic             frame_valid,
    output logic             frame_err
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic            TGT_LVL  = (CHANNEL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        SHIFT = 3'd2,
        LOAD  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // Bit 0 = first sync stage, bit 1 = synchronized copy, bit 2 = history.
    logic [2:0]       bclk_q;
    logic [2:0]       lrck_q;
    logic [1:0]       dat_q;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] frame_q;
    logic             valid_q;
    logic             err_q;

    logic             bclk_rise;
    logic             lrck_edge;
    logic             target_edge;
    logic [WIDTH-1:0] shreg_d;

    assign bclk_rise   = bclk_q[1] & ~bclk_q[2];
    assign lrck_edge   = lrck_q[1] ^ lrck_q[2];
    assign target_edge = lrck_edge & (lrck_q[1] == TGT_LVL);
    assign shreg_d     = {shreg_q[WIDTH-2:0], dat_q[1]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bclk_q <= '0;
            lrck_q <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], AUD_BCLK};
            lrck_q <= {lrck_q[1:0], AUD_ADCLRCK};
            dat_q  <= {dat_q[0], AUD_ADCDAT};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE, WAIT: begin
                    if (target_edge) begin
                        state_q <= SKIP;
                        cnt_q   <= '0;
                    end else if (lrck_edge) begin
                        state_q <= WAIT;
                    end
                end
                SKIP, SHIFT: begin
                    // A word clock edge mid-word wins over any coincident bit.
                    if (lrck_edge) begin
                        err_q <= 1'b1;
                        if (target_edge) begin
                            state_q <= SKIP;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (bclk_rise) begin
                        if (state_q == SKIP) begin
                            state_q <= SHIFT;
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    frame_q <= shreg_q;
                    valid_q <= 1'b1;
                    state_q <= WAIT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign adc_frame   = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_adc_receiver
//  Description : Randomized bench; left (CHANNEL=0) and right (CHANNEL=1)
//                receivers share one I2S stream, each against a word queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_adc_receiver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk  = 1'b0;
    logic        lrck  = 1'b0;
    logic        dat   = 1'b0;

    logic [15:0] frame0, frame1;
    logic        valid0, valid1;
    logic        err0, err1;

    always #5 clk = ~clk;

    i2s_adc_receiver #(.CHANNEL(0), .WIDTH(16)) u_dut0 (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .adc_frame   (frame0),
        .frame_valid (valid0),
        .frame_err   (err0)
    );

    i2s_adc_receiver #(.CHANNEL(1), .WIDTH(16)) u_dut1 (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .adc_frame   (frame1),
        .frame_valid (valid1),
        .frame_err   (err1)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] hold[2]    = '{16'h0, 16'h0};
    bit          armed[2]   = '{1'b0, 1'b0};
    int          exp_err[2] = '{0, 0};
    int          got_err[2] = '{0, 0};
    event        lsb_rise;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic mon(input int ch, input logic v, input logic e, input logic [15:0] f);
        logic [15:0] w;
        int          qsize;
        qsize = (ch == 0) ? exp_q0.size() : exp_q1.size();
        if (v || e) check($sformatf("ch%0d valid_err_overlap", ch), {31'b0, v & e}, 32'd0);
        if (e) got_err[ch]++;
        if (v) begin
            if (qsize == 0) begin
                check($sformatf("ch%0d unexpected_strobe", ch), {31'b0, v}, 32'd0);
            end else begin
                w = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("ch%0d frame", ch), {16'b0, f}, {16'b0, w});
                hold[ch] = w;
            end
        end else begin
            check($sformatf("ch%0d hold", ch), {16'b0, f}, {16'b0, hold[ch]});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, valid0, err0, frame0);
            mon(1, valid1, err1, frame1);
        end
    end

    // Stream edges land 2 ns before a CLK rise so CLK edge counting is exact.
    task automatic half_wait();
        repeat (4) @(negedge clk);
        #3;
    endtask

    task automatic send_bit(input logic l, input logic d);
        half_wait();
        bclk = 1'b0;
        lrck = l;
        dat  = d;
        half_wait();
        bclk = 1'b1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        armed = '{1'b0, 1'b0};
        hold  = '{16'h0, 16'h0};
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("rst async frame0", {16'b0, frame0}, 32'd0);
        check("rst async valid0", {31'b0, valid0}, 32'd0);
        check("rst async err0",   {31'b0, err0},   32'd0);
        check("rst async frame1", {16'b0, frame1}, 32'd0);
        check("rst async valid1", {31'b0, valid1}, 32'd0);
        check("rst async err1",   {31'b0, err1},   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One slot: delay bit, 16 data bits MSB first, zero padding; nbits < 17 truncates.
    task automatic send_slot(input logic lvl, input logic [15:0] w, input int nbits, input int rst_bit);
        int ch;
        ch = lvl ? 1 : 0;
        if (lvl != lrck && rst_n) armed[ch] = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            send_bit(lvl, (i >= 1 && i <= 16) ? w[16-i] : 1'b0);
            if (i == rst_bit) reset_pulse();
            if (i == 16) begin
                if (armed[ch]) begin
                    if (ch == 0) exp_q0.push_back(w);
                    else         exp_q1.push_back(w);
                end
                -> lsb_rise;
            end
        end
        if (nbits < 17 && armed[ch]) exp_err[ch]++;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32, -1);
        send_slot(1'b1, r, 32, -1);
    endtask

    task automatic check_errs(input string tag);
        check({tag, " ch0 errs"}, got_err[0], exp_err[0]);
        check({tag, " ch1 errs"}, got_err[1], exp_err[1]);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset frame0", {16'b0, frame0}, 32'd0);
        check("reset valid0", {31'b0, valid0}, 32'd0);
        check("reset err0",   {31'b0, err0},   32'd0);
        check("reset frame1", {16'b0, frame1}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        repeat (4) send_frame(16'h3A98, 16'h1234);
        check_errs("nominal");
        check("nominal ch0 value", {16'b0, frame0}, 32'h3A98);

        repeat (3) send_frame(16'h0001, 16'hC568);
        check_errs("right");
        check("right ch1 value", {16'b0, frame1}, 32'hC568);

        fork
            send_frame(16'h1357, 16'h2468);
            begin
                @(lsb_rise);
                repeat (3) @(posedge clk);
                #1 check("latency edge3", {31'b0, valid0}, 32'd0);
                @(posedge clk);
                #1 check("latency edge4", {31'b0, valid0}, 32'd1);
                @(posedge clk);
                #1 check("latency edge5", {31'b0, valid0}, 32'd0);
            end
        join

        send_slot(1'b0, 16'h5555, 10, -1);
        send_slot(1'b1, 16'hAAAA, 32, -1);
        send_slot(1'b0, 16'h7FFF, 32, -1);
        send_slot(1'b1, 16'h1111, 10, -1);
        send_slot(1'b0, 16'h2222, 32, -1);
        send_slot(1'b1, 16'h7FFF, 32, -1);
        check_errs("trunc");
        check("trunc expected errs", exp_err[0] + exp_err[1], 32'd2);

        send_slot(1'b0, 16'h0F0F, 32, 7);
        send_slot(1'b1, 16'h3333, 32, -1);
        send_slot(1'b0, 16'h8000, 32, -1);
        send_slot(1'b1, 16'h4444, 32, -1);
        check("reset ch0 first word", {16'b0, frame0}, 32'h8000);
        check_errs("reset");

        for (int k = 0; k < 64; k++) begin
            send_frame(16'($urandom), 16'($urandom));
        end
        send_slot(1'b0, 16'h0000, 32, -1);
        repeat (20) @(negedge clk);
        check_errs("stream");
        check("ch0 pending words", exp_q0.size(), 32'd0);
        check("ch1 pending words", exp_q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
